cla_pipe: RTL and testbench

CLA_PIPE -- requirements
Module: cla_pipe

---
 rtl/cla_pipe.sv | 156 +++++++++++++++
 tb/tb_cla_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups, valid/ready flow.
// Optional signed-overflow output enabled by defining CLA_PIPE_OVF_EN.
module cla_pipe #(
  parameter int unsigned N      = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
`ifdef CLA_PIPE_OVF_EN
  output logic         ovf,
`endif
  output logic         c_out
);

  localparam int W   = int'(N / STAGES);
  localparam int GPS = W / 4;

  // Returns {carry out, carry into bit 3, sum[3:0]} of one lookahead group.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], c[3], p ^ c[3:0]};
  endfunction

  // Each bank carries the full operand and partial-sum vectors; slices not yet
  // consumed / not yet produced simply ride along.
  logic [N-1:0] a_q     [STAGES];
  logic [N-1:0] a_d     [STAGES];
  logic [N-1:0] b_q     [STAGES];
  logic [N-1:0] b_d     [STAGES];
  logic [N-1:0] sum_q   [STAGES];
  logic [N-1:0] sum_d   [STAGES];
  logic         carry_q [STAGES];
  logic         carry_d [STAGES];
  logic         valid_q [STAGES];
  logic         valid_d [STAGES];

  logic         advance;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N-1:0] sum_acc;
  logic         carry;
  logic         carry_msb;
  logic         vld;
  logic [5:0]   grp;
  int           prev;
  int           off;

  assign advance   = !valid_q[STAGES-1] || out_ready;
  assign in_ready  = advance || rst;
  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign c_out     = carry_q[STAGES-1];

  always_comb begin
    op_a      = '0;
    op_b      = '0;
    sum_acc   = '0;
    carry     = 1'b0;
    carry_msb = 1'b0;
    vld       = 1'b0;
    grp       = '0;
    prev      = 0;
    off       = 0;
    for (int s = 0; s < STAGES; s++) begin
      prev = (s > 0) ? s - 1 : 0;
      if (s == 0) begin
        op_a    = a;
        op_b    = b ^ {N{sub}};
        carry   = c_in ^ sub;
        sum_acc = '0;
        vld     = in_valid;
      end else begin
        op_a    = a_q[prev];
        op_b    = b_q[prev];
        carry   = carry_q[prev];
        sum_acc = sum_q[prev];
        vld     = valid_q[prev];
      end
      for (int g = 0; g < GPS; g++) begin
        off                = s * W + g * 4;
        grp                = cla4(op_a[off +: 4], op_b[off +: 4], carry);
        sum_acc[off +: 4]  = grp[3:0];
        carry_msb          = grp[4];
        carry              = grp[5];
      end
      a_d[s]     = op_a;
      b_d[s]     = op_b;
      sum_d[s]   = sum_acc;
      carry_d[s] = carry;
      valid_d[s] = vld;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]     <= '0;
        b_q[s]     <= '0;
        sum_q[s]   <= '0;
        carry_q[s] <= 1'b0;
        valid_q[s] <= 1'b0;
      end
    end else if (advance) begin
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]     <= a_d[s];
        b_q[s]     <= b_d[s];
        sum_q[s]   <= sum_d[s];
        carry_q[s] <= carry_d[s];
        valid_q[s] <= valid_d[s];
      end
    end
  end

`ifdef CLA_PIPE_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // After the loop, carry/carry_msb hold the last stage's MSB carries.
  assign ovf_d = carry_msb ^ carry;
  assign ovf   = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  logic unused_ops;
  assign unused_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};
`else
  logic unused_ops;
  assign unused_ops = ^{a_q[STAGES-1], b_q[STAGES-1], carry_msb};
`endif

endmodule

// File: tb/tb_cla_pipe.sv
// Directed and randomized checks of cla_pipe (N=8, STAGES=2), optional ovf under CLA_PIPE_OVF_EN.
module tb_cla_pipe;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       c_out;
`ifdef CLA_PIPE_OVF_EN
  logic       ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cla_pipe #(.N(8), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef CLA_PIPE_OVF_EN
    .ovf       (ovf),
`endif
    .c_out     (c_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] ta, input logic [7:0] tb,
                       input logic ci, input logic sb);
    in_valid = v;
    a        = ta;
    b        = tb;
    c_in     = ci;
    sub      = sb;
  endtask

  // Reference: {ovf, c_out, sum}
  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic ci, input logic sb);
    logic [7:0] bx;
    logic [8:0] r;
    logic       ov;
    bx = mb ^ {8{sb}};
    r  = {1'b0, ma} + {1'b0, bx} + {8'd0, ci ^ sb};
    ov = (ma[7] == bx[7]) && (r[7] != ma[7]);
    return {ov, r};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 8'h55, 8'h22, 1'b0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || sum !== 8'h00 || c_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b s=%h c=%b exp v=0 s=00 c=0", out_valid, sum, c_out);
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_add_carry();
    drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL add_first_accept got in_ready=%b exp=1", in_ready);
    end
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_latency1 got out_valid=%b exp=0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'h00 || c_out !== 1'b1) begin
      failures++;
      $display("FAIL add_ff_01 got v=%b s=%h c=%b exp v=1 s=00 c=1", out_valid, sum, c_out);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_drain got out_valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_sub();
    drive(1'b1, 8'h05, 8'h07, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'h07, 8'h05, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'hFE || c_out !== 1'b0) begin
      failures++;
      $display("FAIL sub_borrow got v=%b s=%h c=%b exp v=1 s=fe c=0", out_valid, sum, c_out);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'h02 || c_out !== 1'b1) begin
      failures++;
      $display("FAIL sub_noborrow got v=%b s=%h c=%b exp v=1 s=02 c=1", out_valid, sum, c_out);
    end
    tick();
  endtask

`ifdef CLA_PIPE_OVF_EN
  task automatic test_ovf();
    drive(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h80, 8'h01, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'h80 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_add got v=%b s=%h o=%b exp v=1 s=80 o=1", out_valid, sum, ovf);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'h7F || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sub got v=%b s=%h o=%b exp v=1 s=7f o=1", out_valid, sum, ovf);
    end
    tick();
  endtask
`endif

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_first got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
    drive(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h0F, 8'h01, 1'b0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_in_ready_drop got=%b exp=0", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || sum !== 8'h03 || c_out !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got v=%b s=%h c=%b rdy=%b exp v=1 s=03 c=0 rdy=0",
                 i, out_valid, sum, c_out, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'h30) begin
      failures++;
      $display("FAIL bp_release2 got v=%b s=%h exp v=1 s=30", out_valid, sum);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'h10) begin
      failures++;
      $display("FAIL bp_release3 got v=%b s=%h exp v=1 s=10", out_valid, sum);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty got v=%b exp=0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h02, 8'h02, 1'b0, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'h02) begin
      failures++;
      $display("FAIL rm_res1 got v=%b s=%h exp v=1 s=02", out_valid, sum);
    end
    drive(1'b1, 8'h03, 8'h03, 1'b0, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'h04) begin
      failures++;
      $display("FAIL rm_res2 got v=%b s=%h exp v=1 s=04", out_valid, sum);
    end
    drive(1'b1, 8'h04, 8'h04, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || sum !== 8'h00) begin
      failures++;
      $display("FAIL rm_flush got v=%b s=%h exp v=0 s=00", out_valid, sum);
    end
    drive(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rm_no_ghost got v=%b s=%h exp v=0", out_valid, sum);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'h30 || c_out !== 1'b0) begin
      failures++;
      $display("FAIL rm_new_beat got v=%b s=%h c=%b exp v=1 s=30 c=0", out_valid, sum, c_out);
    end
    tick();
  endtask

  task automatic test_random();
    logic [9:0] q[$];
    logic [9:0] exp_v;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while ((sent < 256 || q.size() > 0) && cyc < 6000) begin
      if (sent < 256 && $urandom_range(0, 3) != 0) begin
        drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, c_in, sub));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra got s=%h c=%b exp none", sum, c_out);
        end else begin
          exp_v = q.pop_front();
`ifdef CLA_PIPE_OVF_EN
          if ({ovf, c_out, sum} !== exp_v) begin
            failures++;
            $display("FAIL rand[%0d] got %h exp %h", got, {ovf, c_out, sum}, exp_v);
          end
`else
          if ({c_out, sum} !== exp_v[8:0]) begin
            failures++;
            $display("FAIL rand[%0d] got %h exp %h", got, {c_out, sum}, exp_v[8:0]);
          end
`endif
        end
        got++;
      end
      tick();
      cyc++;
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    out_ready = 1'b1;
    checks++;
    if (got != 256) begin
      failures++;
      $display("FAIL rand_count got=%0d exp=256", got);
    end
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    test_reset();
    test_add_carry();
    test_sub();
`ifdef CLA_PIPE_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
